// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular two-into-one stream arbiter feeding a UART transmitter,
// with a stall timeout that forcibly releases a grant whose owner has gone quiet mid-packet.
module uart_tx_arbiter #(
  parameter int WIDTH_P        = 8,
  parameter int IDLE_TIMEOUT_P = 1024
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               s0_valid_i,
  output logic               s0_ready_o,
  input  logic [WIDTH_P-1:0] s0_data_i,
  input  logic               s0_last_i,
  input  logic               s1_valid_i,
  output logic               s1_ready_o,
  input  logic [WIDTH_P-1:0] s1_data_i,
  input  logic               s1_last_i,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [WIDTH_P-1:0] m_data_o,
  output logic               m_last_o,
  output logic [1:0]         grant_o,
  output logic               timeout_o
);
  localparam int CW = $clog2(IDLE_TIMEOUT_P + 1);
  localparam logic [CW-1:0] LIMIT = CW'(IDLE_TIMEOUT_P - 1);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;
  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] stall_q, stall_d;
  logic          timeout_q, timeout_d;
  logic          g0, g1, sel_valid, sel_last, fire, expire;
  always_comb begin
    g0         = state_q == GRANT0;
    g1         = state_q == GRANT1;
    sel_valid  = g0 ? s0_valid_i : g1 ? s1_valid_i : 1'b0;
    sel_last   = g0 ? s0_last_i : g1 ? s1_last_i : 1'b0;
    m_valid_o  = sel_valid;
    m_last_o   = sel_last;
    m_data_o   = g0 ? s0_data_i : g1 ? s1_data_i : '0;
    s0_ready_o = g0 & m_ready_i;
    s1_ready_o = g1 & m_ready_i;
    grant_o    = {g1, g0};
    timeout_o  = timeout_q;
    fire       = sel_valid & m_ready_i;
    // Only an absent owner counts as stalled; downstream backpressure never does.
    expire     = (g0 | g1) & ~sel_valid & (stall_q >= LIMIT);
    state_d    = state_q;
    prio_d     = prio_q;
    stall_d    = '0;
    timeout_d  = expire;
    if (state_q == IDLE) begin
      state_d = (s0_valid_i & s1_valid_i) ? (prio_q ? GRANT1 : GRANT0) :
                s0_valid_i ? GRANT0 : s1_valid_i ? GRANT1 : IDLE;
    end else if ((fire & sel_last) | expire) begin
      state_d = IDLE;
      prio_d  = g0;
    end else begin
      stall_d = sel_valid ? '0 : stall_q + CW'(stall_q != '1);
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end
endmodule
